q_byte_serializer: RTL and testbench

Q_BYTE_SERIALIZER -- requirements
Module: q_byte_serializer

---
 rtl/q_ser_pkg.sv | 25 ++
 rtl/q_byte_serializer.sv | 98 +++++++++
 tb/tb_q_byte_serializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/q_ser_pkg.sv
// Shared constants, FSM state type and checksum helper for q_byte_serializer.
// The CSUM state and the checksum helper exist only when Q_SER_CHECKSUM_EN is defined.
package q_ser_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

`ifdef Q_SER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StCsum} state_e;

  // XOR of every byte in the word; order-independent, so MSB_FIRST does not matter.
  function automatic logic [BYTE_W-1:0] word_xor(input logic [WORD_W-1:0] word);
    logic [BYTE_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      acc ^= word[i*BYTE_W +: BYTE_W];
    end
    return acc;
  endfunction
`else
  typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

endpackage

// File: rtl/q_byte_serializer.sv
// Serializes one 64-bit word into bytes over a valid/ready stream, one word at a time.
// Defining Q_SER_CHECKSUM_EN appends a ninth XOR-checksum byte to every frame.
module q_byte_serializer
  import q_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [2:0]          idx_nxt;

  // Maps the frame byte index onto the byte lane of the held word.
  function automatic logic [2:0] byte_pos(input logic [2:0] idx);
    return MSB_FIRST ? (3'd7 - idx) : idx;
  endfunction

  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          hold_d  = in_data;
          idx_d   = 3'd0;
          data_d  = in_data[byte_pos(3'd0)*BYTE_W +: BYTE_W];
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          idx_d = idx_nxt;
          if (idx_q == 3'd7) begin
`ifdef Q_SER_CHECKSUM_EN
            data_d  = word_xor(hold_q);
            state_d = StCsum;
`else
            // out_data keeps the final byte while idle.
            state_d = StIdle;
`endif
          end else begin
            data_d = hold_q[byte_pos(idx_nxt)*BYTE_W +: BYTE_W];
          end
        end
      end
`ifdef Q_SER_CHECKSUM_EN
      StCsum: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      hold_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q != StIdle);
  assign busy      = (state_q != StIdle);
  assign out_data  = data_q;
`ifdef Q_SER_CHECKSUM_EN
  assign out_last  = (state_q == StCsum);
`else
  assign out_last  = (state_q == StSend) && (idx_q == 3'd7);
`endif

endmodule

// File: tb/tb_q_byte_serializer.sv
// Bench for q_byte_serializer: an MSB-first and an LSB-first instance run in lockstep
// against a queue of expected bytes; frame length follows Q_SER_CHECKSUM_EN.
module tb_q_byte_serializer;

`ifdef Q_SER_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] l;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic        in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [7:0]  out_data_m, out_data_l;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  q_byte_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .out_last(out_last_m), .busy(busy_m)
  );

  q_byte_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .out_last(out_last_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  // Expected bytes of one frame for both byte orders.
  task automatic push_word(input logic [63:0] w);
    exp_t        e;
    logic [63:0] t;
    logic [7:0]  cs;
    cs = 8'h00;
    for (int k = 0; k < 8; k++) begin
      t = w >> (8 * (7 - k));
      e.m = t[7:0];
      t = w >> (8 * k);
      e.l = t[7:0];
      cs = cs ^ e.l;
      e.last = (k == NB - 1);
      sb.push_back(e);
    end
    if (NB == 9) begin
      e.m = cs;
      e.l = cs;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 64'hDEADBEEF_CAFEF00D; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({out_valid_m, out_valid_l, out_last_m, out_last_l, busy_m, busy_l,
         out_data_m, out_data_l} !== {6'b0, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: v=%b%b last=%b%b busy=%b%b d=%h/%h, want all zero",
               out_valid_m, out_valid_l, out_last_m, out_last_l, busy_m, busy_l,
               out_data_m, out_data_l);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready_m, in_ready_l, busy_m, busy_l} !== 4'b1100) begin
      n_err++;
      $display("FAIL ready_after_reset: rdy=%b%b busy=%b%b, want rdy=11 busy=00",
               in_ready_m, in_ready_l, busy_m, busy_l);
    end
  endtask

  task automatic test_basic();
    logic [63:0] words[4];
    exp_t        e;
    words[0] = 64'h0123456789ABCDEF;
    words[1] = 64'hFF00FF00FF00FF00;
    words[2] = 64'h0000000000000001;
    words[3] = {$urandom(), $urandom()};
    for (int w = 0; w < 4; w++) begin
      in_data = words[w]; in_valid = 1'b1; out_ready = 1'b1;
      push_word(words[w]);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
        e = sb.pop_front();
        n_vec++;
        if ({out_valid_m, out_valid_l, in_ready_m, in_ready_l, out_data_m, out_data_l,
             out_last_m, out_last_l} !== {4'b1100, e.m, e.l, e.last, e.last}) begin
          n_err++;
          $display("FAIL basic w%0d b%0d: v=%b%b rdy=%b%b d=%h/%h last=%b%b, want d=%h/%h last=%b",
                   w, k, out_valid_m, out_valid_l, in_ready_m, in_ready_l, out_data_m,
                   out_data_l, out_last_m, out_last_l, e.m, e.l, e.last);
        end
        @(negedge clk);
      end
      n_vec++;
      if ({out_valid_m, out_valid_l, out_last_m, out_last_l, busy_m, busy_l, in_ready_m,
           in_ready_l, out_data_m, out_data_l} !== {8'b00000011, e.m, e.l}) begin
        n_err++;
        $display("FAIL basic_idle w%0d: v=%b%b busy=%b%b rdy=%b%b d=%h/%h, want idle d=%h/%h",
                 w, out_valid_m, out_valid_l, busy_m, busy_l, in_ready_m, in_ready_l,
                 out_data_m, out_data_l, e.m, e.l);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    in_data = 64'h1122334455667788; in_valid = 1'b1; out_ready = 1'b1;
    push_word(in_data);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          e = sb[0];
          n_vec++;
          if ({out_valid_m, out_valid_l, out_data_m, out_data_l, out_last_m, out_last_l} !==
              {2'b11, e.m, e.l, e.last, e.last}) begin
            n_err++;
            $display("FAIL stall_hold c%0d: v=%b%b d=%h/%h last=%b%b, want d=%h/%h last=%b",
                     s, out_valid_m, out_valid_l, out_data_m, out_data_l, out_last_m,
                     out_last_l, e.m, e.l, e.last);
          end
        end
        out_ready = 1'b1;
      end
      e = sb.pop_front();
      n_vec++;
      if ({out_valid_m, out_valid_l, out_data_m, out_data_l, out_last_m, out_last_l} !==
          {2'b11, e.m, e.l, e.last, e.last}) begin
        n_err++;
        $display("FAIL stall b%0d: v=%b%b d=%h/%h last=%b%b, want d=%h/%h last=%b",
                 k, out_valid_m, out_valid_l, out_data_m, out_data_l, out_last_m, out_last_l,
                 e.m, e.l, e.last);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    in_data = 64'hA5A5_0F0F_3C3C_9669; in_valid = 1'b1; out_ready = 1'b1;
    push_word(in_data);
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      // Change the offered word mid-frame; it must only be taken once idle.
      in_data = (f == 0) ? 64'h8040_2010_0804_0201 : 64'h0;
      in_valid = (f == 0);
      for (int k = 0; k < NB; k++) begin
        e = sb.pop_front();
        n_vec++;
        if ({out_valid_m, out_valid_l, in_ready_m, in_ready_l, out_data_m, out_data_l,
             out_last_m, out_last_l} !== {4'b1100, e.m, e.l, e.last, e.last}) begin
          n_err++;
          $display("FAIL b2b f%0d b%0d: v=%b%b rdy=%b%b d=%h/%h last=%b%b, want d=%h/%h last=%b",
                   f, k, out_valid_m, out_valid_l, in_ready_m, in_ready_l, out_data_m,
                   out_data_l, out_last_m, out_last_l, e.m, e.l, e.last);
        end
        @(negedge clk);
      end
      n_vec++;
      if ({out_valid_m, out_valid_l, in_ready_m, in_ready_l} !== 4'b0011) begin
        n_err++;
        $display("FAIL b2b_gap f%0d: v=%b%b rdy=%b%b, want v=00 rdy=11",
                 f, out_valid_m, out_valid_l, in_ready_m, in_ready_l);
      end
      if (f == 0) push_word(in_data);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    in_data = 64'hC001_D00D_FEED_BEEF; in_valid = 1'b1; out_ready = 1'b1;
    push_word(in_data);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = sb.pop_front();
      n_vec++;
      if ({out_data_m, out_data_l} !== {e.m, e.l}) begin
        n_err++;
        $display("FAIL pre_reset b%0d: d=%h/%h, want %h/%h", k, out_data_m, out_data_l, e.m, e.l);
      end
      if (k < 4) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid_m, out_valid_l, busy_m, busy_l, in_ready_m, in_ready_l, out_data_m,
         out_data_l} !== {6'b000011, 16'h0000}) begin
      n_err++;
      $display("FAIL mid_reset: v=%b%b busy=%b%b rdy=%b%b d=%h/%h, want idle d=00/00",
               out_valid_m, out_valid_l, busy_m, busy_l, in_ready_m, in_ready_l,
               out_data_m, out_data_l);
    end
    sb.delete();
    reset = 1'b0;
    in_data = 64'h0102_0304_0506_0708; in_valid = 1'b1;
    push_word(in_data);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      e = sb.pop_front();
      n_vec++;
      if ({out_valid_m, out_valid_l, out_data_m, out_data_l, out_last_m, out_last_l} !==
          {2'b11, e.m, e.l, e.last, e.last}) begin
        n_err++;
        $display("FAIL post_reset b%0d: v=%b%b d=%h/%h last=%b%b, want d=%h/%h last=%b",
                 k, out_valid_m, out_valid_l, out_data_m, out_data_l, out_last_m, out_last_l,
                 e.m, e.l, e.last);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
